// File: rtl/echo_indication_arb.sv
// Shares one EchoIndication port (heard/heards) between two requesters, each behind its own FIFO.
// Latency: an entry pushed at edge N can issue in cycle N+1; at most one downstream issue per cycle.
// Backpressure: rN_*__RDY tracks FIFO not-full; a head whose method RDY is low is skipped, not blocking.

module echo_indication_arb_fifo #(
  parameter int WIDTH = 97,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_vld,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_dat
);
  // Generic DEPTH-entry FIFO with wrap-bit pointers.
  // Latency: written entry visible at head the cycle after the push edge.
  // Backpressure: pushes while full and pops while empty are ignored.

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign head_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_vld && !full) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_vld && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push_vld && !full) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

module echo_indication_arb #(
  parameter int DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        r0_heard__ENA,
  input  logic [31:0] r0_heard_v,
  output logic        r0_heard__RDY,
  input  logic        r0_heards__ENA,
  input  logic [15:0] r0_heards_ahEnd,
  input  logic [15:0] r0_heards_ahFrontEnd,
  input  logic [7:0]  r0_heards_ahBackSync,
  input  logic [7:0]  r0_heards_ahSyncWidth,
  input  logic [15:0] r0_heards_avEnd,
  input  logic [15:0] r0_heards_avFrontEnd,
  input  logic [7:0]  r0_heards_avBackSync,
  input  logic [7:0]  r0_heards_avSyncWidth,
  output logic        r0_heards__RDY,
  input  logic        r1_heard__ENA,
  input  logic [31:0] r1_heard_v,
  output logic        r1_heard__RDY,
  input  logic        r1_heards__ENA,
  input  logic [15:0] r1_heards_ahEnd,
  input  logic [15:0] r1_heards_ahFrontEnd,
  input  logic [7:0]  r1_heards_ahBackSync,
  input  logic [7:0]  r1_heards_ahSyncWidth,
  input  logic [15:0] r1_heards_avEnd,
  input  logic [15:0] r1_heards_avFrontEnd,
  input  logic [7:0]  r1_heards_avBackSync,
  input  logic [7:0]  r1_heards_avSyncWidth,
  output logic        r1_heards__RDY,
  output logic        ind_heard__ENA,
  output logic [31:0] ind_heard_v,
  input  logic        ind_heard__RDY,
  output logic        ind_heards__ENA,
  output logic [15:0] ind_heards_ahEnd,
  output logic [15:0] ind_heards_ahFrontEnd,
  output logic [7:0]  ind_heards_ahBackSync,
  output logic [7:0]  ind_heards_ahSyncWidth,
  output logic [15:0] ind_heards_avEnd,
  output logic [15:0] ind_heards_avFrontEnd,
  output logic [7:0]  ind_heards_avBackSync,
  output logic [7:0]  ind_heards_avSyncWidth,
  input  logic        ind_heards__RDY,
  output logic        r0_err,
  output logic        r1_err
);

  typedef struct packed {
    logic [15:0] ah_end;
    logic [15:0] ah_front_end;
    logic [7:0]  ah_back_sync;
    logic [7:0]  ah_sync_width;
    logic [15:0] av_end;
    logic [15:0] av_front_end;
    logic [7:0]  av_back_sync;
    logic [7:0]  av_sync_width;
  } heards_t;

  // kind 0 = heard (v in body[31:0]), kind 1 = heards.
  typedef struct packed {
    logic    kind;
    heards_t body;
  } entry_t;

  logic [1:0] heard_ena;
  logic [1:0] heards_ena;
  entry_t     heard_ent  [2];
  entry_t     heards_ent [2];
  entry_t     push_dat   [2];
  entry_t     head       [2];
  logic [1:0] push_vld;
  logic [1:0] pop_vld;
  logic [1:0] full;
  logic [1:0] empty;
  logic [1:0] elig;
  logic [1:0] err;
  logic       gnt;
  logic       issue;
  logic       last_grant;
  entry_t     sel;

  assign heard_ena  = {r1_heard__ENA, r0_heard__ENA};
  assign heards_ena = {r1_heards__ENA, r0_heards__ENA};

  assign heard_ent[0] = {1'b0, 64'd0, r0_heard_v};
  assign heard_ent[1] = {1'b0, 64'd0, r1_heard_v};
  assign heards_ent[0] = {1'b1,
                          r0_heards_ahEnd, r0_heards_ahFrontEnd, r0_heards_ahBackSync, r0_heards_ahSyncWidth,
                          r0_heards_avEnd, r0_heards_avFrontEnd, r0_heards_avBackSync, r0_heards_avSyncWidth};
  assign heards_ent[1] = {1'b1,
                          r1_heards_ahEnd, r1_heards_ahFrontEnd, r1_heards_ahBackSync, r1_heards_ahSyncWidth,
                          r1_heards_avEnd, r1_heards_avFrontEnd, r1_heards_avBackSync, r1_heards_avSyncWidth};

  for (genvar n = 0; n < 2; n++) begin : g_req
    // heards wins a same-cycle collision; the heard call is dropped and flagged.
    assign push_vld[n] = (heard_ena[n] | heards_ena[n]) & ~full[n] & ~RST;
    assign push_dat[n] = heards_ena[n] ? heards_ent[n] : heard_ent[n];

    echo_indication_arb_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk      (CLK),
      .rst      (RST),
      .push_vld (push_vld[n]),
      .push_dat (push_dat[n]),
      .pop_vld  (pop_vld[n]),
      .full     (full[n]),
      .empty    (empty[n]),
      .head_dat (head[n])
    );

    assign elig[n] = ~empty[n] & (head[n].kind ? ind_heards__RDY : ind_heard__RDY);

    always_ff @(posedge CLK) begin
      if (RST) begin
        err[n] <= 1'b0;
      end else if (((heard_ena[n] | heards_ena[n]) & full[n]) | (heard_ena[n] & heards_ena[n])) begin
        err[n] <= 1'b1;
      end
    end
  end

  assign r0_heard__RDY  = ~full[0];
  assign r0_heards__RDY = ~full[0];
  assign r1_heard__RDY  = ~full[1];
  assign r1_heards__RDY = ~full[1];
  assign r0_err         = err[0];
  assign r1_err         = err[1];

  // Ties go to the requester that did not issue last.
  assign gnt        = (elig[0] & elig[1]) ? ~last_grant : elig[1];
  assign issue      = (elig[0] | elig[1]) & ~RST;
  assign sel        = head[gnt];
  assign pop_vld[0] = issue & ~gnt;
  assign pop_vld[1] = issue & gnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      last_grant <= 1'b1;
    end else if (issue) begin
      last_grant <= gnt;
    end
  end

  assign ind_heard__ENA  = issue & ~sel.kind;
  assign ind_heards__ENA = issue & sel.kind;

  assign ind_heard_v            = ind_heard__ENA  ? sel.body[31:0]         : 32'd0;
  assign ind_heards_ahEnd       = ind_heards__ENA ? sel.body.ah_end        : 16'd0;
  assign ind_heards_ahFrontEnd  = ind_heards__ENA ? sel.body.ah_front_end  : 16'd0;
  assign ind_heards_ahBackSync  = ind_heards__ENA ? sel.body.ah_back_sync  : 8'd0;
  assign ind_heards_ahSyncWidth = ind_heards__ENA ? sel.body.ah_sync_width : 8'd0;
  assign ind_heards_avEnd       = ind_heards__ENA ? sel.body.av_end        : 16'd0;
  assign ind_heards_avFrontEnd  = ind_heards__ENA ? sel.body.av_front_end  : 16'd0;
  assign ind_heards_avBackSync  = ind_heards__ENA ? sel.body.av_back_sync  : 8'd0;
  assign ind_heards_avSyncWidth = ind_heards__ENA ? sel.body.av_sync_width : 8'd0;

endmodule

// File: tb/tb_echo_indication_arb.sv
// Bench for echo_indication_arb: scoreboard of expected downstream messages, one task per scenario.
module tb_echo_indication_arb;

  logic        CLK = 1'b0;
  logic        RST;
  logic        r0_heard__ENA, r1_heard__ENA, r0_heards__ENA, r1_heards__ENA;
  logic [31:0] r0_heard_v, r1_heard_v;
  logic        r0_heard__RDY, r1_heard__RDY, r0_heards__RDY, r1_heards__RDY;
  logic [15:0] r0_heards_ahEnd, r0_heards_ahFrontEnd, r0_heards_avEnd, r0_heards_avFrontEnd;
  logic [7:0]  r0_heards_ahBackSync, r0_heards_ahSyncWidth, r0_heards_avBackSync, r0_heards_avSyncWidth;
  logic [15:0] r1_heards_ahEnd, r1_heards_ahFrontEnd, r1_heards_avEnd, r1_heards_avFrontEnd;
  logic [7:0]  r1_heards_ahBackSync, r1_heards_ahSyncWidth, r1_heards_avBackSync, r1_heards_avSyncWidth;
  logic        ind_heard__ENA, ind_heards__ENA, ind_heard__RDY, ind_heards__RDY;
  logic [31:0] ind_heard_v;
  logic [15:0] ind_heards_ahEnd, ind_heards_ahFrontEnd, ind_heards_avEnd, ind_heards_avFrontEnd;
  logic [7:0]  ind_heards_ahBackSync, ind_heards_ahSyncWidth, ind_heards_avBackSync, ind_heards_avSyncWidth;
  logic        r0_err, r1_err;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [96:0] exp_q [$];
  logic [96:0] exp_e;
  logic        obs_vld;
  logic        obs_both;
  logic [96:0] obs_dat;

  always #5 CLK = ~CLK;

  echo_indication_arb #(.DEPTH(2)) dut (
    .CLK(CLK), .RST(RST),
    .r0_heard__ENA(r0_heard__ENA), .r0_heard_v(r0_heard_v), .r0_heard__RDY(r0_heard__RDY),
    .r0_heards__ENA(r0_heards__ENA),
    .r0_heards_ahEnd(r0_heards_ahEnd), .r0_heards_ahFrontEnd(r0_heards_ahFrontEnd),
    .r0_heards_ahBackSync(r0_heards_ahBackSync), .r0_heards_ahSyncWidth(r0_heards_ahSyncWidth),
    .r0_heards_avEnd(r0_heards_avEnd), .r0_heards_avFrontEnd(r0_heards_avFrontEnd),
    .r0_heards_avBackSync(r0_heards_avBackSync), .r0_heards_avSyncWidth(r0_heards_avSyncWidth),
    .r0_heards__RDY(r0_heards__RDY),
    .r1_heard__ENA(r1_heard__ENA), .r1_heard_v(r1_heard_v), .r1_heard__RDY(r1_heard__RDY),
    .r1_heards__ENA(r1_heards__ENA),
    .r1_heards_ahEnd(r1_heards_ahEnd), .r1_heards_ahFrontEnd(r1_heards_ahFrontEnd),
    .r1_heards_ahBackSync(r1_heards_ahBackSync), .r1_heards_ahSyncWidth(r1_heards_ahSyncWidth),
    .r1_heards_avEnd(r1_heards_avEnd), .r1_heards_avFrontEnd(r1_heards_avFrontEnd),
    .r1_heards_avBackSync(r1_heards_avBackSync), .r1_heards_avSyncWidth(r1_heards_avSyncWidth),
    .r1_heards__RDY(r1_heards__RDY),
    .ind_heard__ENA(ind_heard__ENA), .ind_heard_v(ind_heard_v), .ind_heard__RDY(ind_heard__RDY),
    .ind_heards__ENA(ind_heards__ENA),
    .ind_heards_ahEnd(ind_heards_ahEnd), .ind_heards_ahFrontEnd(ind_heards_ahFrontEnd),
    .ind_heards_ahBackSync(ind_heards_ahBackSync), .ind_heards_ahSyncWidth(ind_heards_ahSyncWidth),
    .ind_heards_avEnd(ind_heards_avEnd), .ind_heards_avFrontEnd(ind_heards_avFrontEnd),
    .ind_heards_avBackSync(ind_heards_avBackSync), .ind_heards_avSyncWidth(ind_heards_avSyncWidth),
    .ind_heards__RDY(ind_heards__RDY),
    .r0_err(r0_err), .r1_err(r1_err)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic observe();
    #1;
    obs_vld  = ind_heard__ENA | ind_heards__ENA;
    obs_both = ind_heard__ENA & ind_heards__ENA;
    if (ind_heards__ENA)
      obs_dat = {1'b1, ind_heards_ahEnd, ind_heards_ahFrontEnd, ind_heards_ahBackSync, ind_heards_ahSyncWidth,
                 ind_heards_avEnd, ind_heards_avFrontEnd, ind_heards_avBackSync, ind_heards_avSyncWidth};
    else
      obs_dat = {1'b0, 64'd0, ind_heard_v};
  endtask

  task automatic idle();
    r0_heard__ENA = 0; r1_heard__ENA = 0; r0_heards__ENA = 0; r1_heards__ENA = 0;
  endtask

  task automatic set_heards(input int n, input logic [95:0] f);
    if (n == 0)
      {r0_heards_ahEnd, r0_heards_ahFrontEnd, r0_heards_ahBackSync, r0_heards_ahSyncWidth,
       r0_heards_avEnd, r0_heards_avFrontEnd, r0_heards_avBackSync, r0_heards_avSyncWidth} = f;
    else
      {r1_heards_ahEnd, r1_heards_ahFrontEnd, r1_heards_ahBackSync, r1_heards_ahSyncWidth,
       r1_heards_avEnd, r1_heards_avFrontEnd, r1_heards_avBackSync, r1_heards_avSyncWidth} = f;
  endtask

  task automatic do_reset();
    idle();
    ind_heard__RDY = 1; ind_heards__RDY = 1;
    RST = 1;
    tick();
    tick();
    RST = 0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    idle();
    ind_heard__RDY = 1; ind_heards__RDY = 1;
    r0_heard_v = 0; r1_heard_v = 0; set_heards(0, '0); set_heards(1, '0);
    RST = 1;
    tick();
    observe();
    n_tests++;
    if (obs_vld !== 1'b0) begin n_fail++; $display("FAIL reset_during_ena got=%b exp=0", obs_vld); end
    tick();
    RST = 0;
    observe();
    n_tests++;
    if (obs_vld !== 1'b0) begin n_fail++; $display("FAIL reset_ena got=%b exp=0", obs_vld); end
    n_tests++;
    if ({ind_heard_v, ind_heards_ahEnd, ind_heards_avSyncWidth} !== 56'd0) begin
      n_fail++; $display("FAIL reset_payload got=%h exp=0", {ind_heard_v, ind_heards_ahEnd, ind_heards_avSyncWidth});
    end
    n_tests++;
    if ({r0_heard__RDY, r0_heards__RDY, r1_heard__RDY, r1_heards__RDY} !== 4'b1111) begin
      n_fail++; $display("FAIL reset_rdy got=%b exp=1111", {r0_heard__RDY, r0_heards__RDY, r1_heard__RDY, r1_heards__RDY});
    end
    n_tests++;
    if ({r0_err, r1_err} !== 2'b00) begin n_fail++; $display("FAIL reset_err got=%b exp=00", {r0_err, r1_err}); end
  endtask

  task automatic test_single_heard();
    int got = 0;
    do_reset();
    r0_heard__ENA = 1; r0_heard_v = 32'h12345678;
    exp_q.push_back({1'b0, 64'd0, 32'h12345678});
    observe();
    n_tests++;
    if (obs_vld !== 1'b0) begin n_fail++; $display("FAIL single_bypass got=%b exp=0", obs_vld); end
    tick();
    idle();
    observe();
    n_tests++;
    if (ind_heard__ENA !== 1'b1 || ind_heards__ENA !== 1'b0) begin
      n_fail++; $display("FAIL single_ena got=%b%b exp=10", ind_heard__ENA, ind_heards__ENA);
    end
    if (obs_vld) begin
      got++;
      n_tests++;
      exp_e = exp_q.pop_front();
      if (obs_dat !== exp_e) begin n_fail++; $display("FAIL single_data got=%h exp=%h", obs_dat, exp_e); end
    end
    tick();
    observe();
    n_tests++;
    if (obs_vld !== 1'b0) begin n_fail++; $display("FAIL single_once got=%b exp=0", obs_vld); end
    n_tests++;
    if (got != 1 || {r0_err, r1_err} !== 2'b00) begin
      n_fail++; $display("FAIL single_count got=%0d err=%b exp=1 err=00", got, {r0_err, r1_err});
    end
  endtask

  task automatic test_back_to_back();
    int i0 = 0, i1 = 0, got = 0;
    logic saw_full0 = 0, saw_full1 = 0, saw_both = 0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back({1'b0, 64'd0, 32'h10 + k});
      exp_q.push_back({1'b0, 64'd0, 32'h20 + k});
    end
    for (int c = 0; c < 40 && got < 8; c++) begin
      r0_heard__ENA = (i0 < 4) && r0_heard__RDY; r0_heard_v = 32'h10 + i0;
      r1_heard__ENA = (i1 < 4) && r1_heard__RDY; r1_heard_v = 32'h20 + i1;
      if (!r0_heard__RDY) saw_full0 = 1;
      if (!r1_heard__RDY) saw_full1 = 1;
      observe();
      if (obs_both) saw_both = 1;
      if (obs_vld) begin
        got++;
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL b2b_extra got=%h exp=none", obs_dat); end
        else begin
          exp_e = exp_q.pop_front();
          if (obs_dat !== exp_e) begin n_fail++; $display("FAIL b2b_order got=%h exp=%h", obs_dat, exp_e); end
        end
      end
      tick();
      if (r0_heard__ENA) i0++;
      if (r1_heard__ENA) i1++;
    end
    idle();
    n_tests++;
    if (got != 8) begin n_fail++; $display("FAIL b2b_count got=%0d exp=8", got); end
    n_tests++;
    if ({saw_full0, saw_full1} !== 2'b11) begin n_fail++; $display("FAIL b2b_rdy_drop got=%b exp=11", {saw_full0, saw_full1}); end
    n_tests++;
    if (saw_both !== 1'b0) begin n_fail++; $display("FAIL b2b_dual_ena got=%b exp=0", saw_both); end
  endtask

  task automatic test_no_hol();
    logic [95:0] f = {16'h0320, 16'h0300, 8'h10, 8'h08, 16'h0210, 16'h01E0, 8'h04, 8'h02};
    int got = 0;
    logic heards_while_low = 0;
    do_reset();
    ind_heards__RDY = 0;
    r0_heards__ENA = 1; set_heards(0, f);
    r1_heard__ENA = 1; r1_heard_v = 32'hAA;
    exp_q.push_back({1'b0, 64'd0, 32'hAA});
    exp_q.push_back({1'b1, f});
    tick();
    idle();
    for (int c = 0; c < 8; c++) begin
      if (c == 4) ind_heards__RDY = 1;
      observe();
      if (!ind_heards__RDY && ind_heards__ENA) heards_while_low = 1;
      if (obs_vld) begin
        got++;
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL nohol_extra got=%h exp=none", obs_dat); end
        else begin
          exp_e = exp_q.pop_front();
          if (obs_dat !== exp_e) begin n_fail++; $display("FAIL nohol_data got=%h exp=%h", obs_dat, exp_e); end
        end
      end
      if (c == 3) begin
        n_tests++;
        if (got != 1) begin n_fail++; $display("FAIL nohol_r1_first got=%0d exp=1", got); end
      end
      tick();
    end
    n_tests++;
    if (got != 2 || heards_while_low) begin
      n_fail++; $display("FAIL nohol_count got=%0d low_ena=%b exp=2 low_ena=0", got, heards_while_low);
    end
  endtask

  task automatic test_dual_ena();
    logic [95:0] g = {16'h1111, 16'h2222, 8'h33, 8'h44, 16'h5555, 16'h6666, 8'h77, 8'h88};
    int got = 0;
    do_reset();
    r1_heard__ENA = 1; r1_heard_v = 32'hBB;
    r1_heards__ENA = 1; set_heards(1, g);
    exp_q.push_back({1'b1, g});
    tick();
    idle();
    for (int c = 0; c < 10; c++) begin
      if (c == 4) begin r1_heard__ENA = 1; r1_heard_v = 32'hCC; exp_q.push_back({1'b0, 64'd0, 32'hCC}); end
      else r1_heard__ENA = 0;
      observe();
      if (obs_vld) begin
        got++;
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL dual_extra got=%h exp=none", obs_dat); end
        else begin
          exp_e = exp_q.pop_front();
          if (obs_dat !== exp_e) begin n_fail++; $display("FAIL dual_data got=%h exp=%h", obs_dat, exp_e); end
        end
      end
      tick();
    end
    idle();
    n_tests++;
    if (got != 2) begin n_fail++; $display("FAIL dual_count got=%0d exp=2", got); end
    n_tests++;
    if ({r1_err, r0_err} !== 2'b10) begin n_fail++; $display("FAIL dual_err_sticky got=%b exp=10", {r1_err, r0_err}); end
  endtask

  task automatic test_overflow();
    int got = 0;
    do_reset();
    ind_heard__RDY = 0;
    r0_heard__ENA = 1; r0_heard_v = 32'h31; exp_q.push_back({1'b0, 64'd0, 32'h31});
    tick();
    r0_heard_v = 32'h32; exp_q.push_back({1'b0, 64'd0, 32'h32});
    tick();
    n_tests++;
    if (r0_heard__RDY !== 1'b0) begin n_fail++; $display("FAIL ovf_rdy got=%b exp=0", r0_heard__RDY); end
    n_tests++;
    if (r0_err !== 1'b0) begin n_fail++; $display("FAIL ovf_err_pre got=%b exp=0", r0_err); end
    r0_heard_v = 32'h33;
    tick();
    idle();
    n_tests++;
    if (r0_err !== 1'b1) begin n_fail++; $display("FAIL ovf_err got=%b exp=1", r0_err); end
    ind_heard__RDY = 1;
    for (int c = 0; c < 6; c++) begin
      observe();
      if (obs_vld) begin
        got++;
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL ovf_extra got=%h exp=none", obs_dat); end
        else begin
          exp_e = exp_q.pop_front();
          if (obs_dat !== exp_e) begin n_fail++; $display("FAIL ovf_data got=%h exp=%h", obs_dat, exp_e); end
        end
      end
      tick();
    end
    n_tests++;
    if (got != 2) begin n_fail++; $display("FAIL ovf_count got=%0d exp=2", got); end
  endtask

  task automatic test_reset_midstream();
    int got = 0;
    do_reset();
    ind_heard__RDY = 0; ind_heards__RDY = 0;
    r0_heard__ENA = 1; r0_heard_v = 32'h41; r1_heard__ENA = 1; r1_heard_v = 32'h51;
    tick();
    r0_heard_v = 32'h42; r1_heard_v = 32'h52;
    tick();
    r0_heard__ENA = 0; r1_heard_v = 32'h53;
    tick();
    idle();
    n_tests++;
    if ({r1_err, r0_heard__RDY, r1_heard__RDY} !== 3'b100) begin
      n_fail++; $display("FAIL mid_pre got=%b exp=100", {r1_err, r0_heard__RDY, r1_heard__RDY});
    end
    ind_heard__RDY = 1; ind_heards__RDY = 1;
    RST = 1;
    observe();
    n_tests++;
    if (obs_vld !== 1'b0) begin n_fail++; $display("FAIL mid_during_ena got=%b exp=0", obs_vld); end
    tick();
    RST = 0;
    observe();
    n_tests++;
    if ({obs_vld, r0_err, r1_err} !== 3'b000) begin
      n_fail++; $display("FAIL mid_after got=%b exp=000", {obs_vld, r0_err, r1_err});
    end
    n_tests++;
    if ({r0_heard__RDY, r0_heards__RDY, r1_heard__RDY, r1_heards__RDY} !== 4'b1111) begin
      n_fail++; $display("FAIL mid_rdy got=%b exp=1111", {r0_heard__RDY, r0_heards__RDY, r1_heard__RDY, r1_heards__RDY});
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      observe();
      if (obs_vld) got++;
    end
    n_tests++;
    if (got != 0) begin n_fail++; $display("FAIL mid_lost got=%0d exp=0", got); end
    r0_heard__ENA = 1; r0_heard_v = 32'h61; exp_q.push_back({1'b0, 64'd0, 32'h61});
    r1_heard__ENA = 1; r1_heard_v = 32'h71; exp_q.push_back({1'b0, 64'd0, 32'h71});
    tick();
    idle();
    for (int c = 0; c < 5; c++) begin
      observe();
      if (obs_vld) begin
        got++;
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL mid_extra got=%h exp=none", obs_dat); end
        else begin
          exp_e = exp_q.pop_front();
          if (obs_dat !== exp_e) begin n_fail++; $display("FAIL mid_tie got=%h exp=%h", obs_dat, exp_e); end
        end
      end
      tick();
    end
    n_tests++;
    if (got != 2) begin n_fail++; $display("FAIL mid_count got=%0d exp=2", got); end
  endtask

  initial begin
    test_reset();
    test_single_heard();
    test_back_to_back();
    test_no_hol();
    test_dual_ena();
    test_overflow();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
